core_inst_seq: RTL and testbench
================================

CORE_INST_SEQ -- requirements
Module: core_inst_seq

Interface
REQ-001 Parameter row, default 8: PE array rows; sets the weight-settle gap length.
REQ-002 Parameter col, default 8: PE array columns; sets the weight-word count per tile.
REQ-003 clk  in  1: single clock; all state updates on the rising edge.
REQ-004 reset  in  1: asynchronous, active-low; reset=0 forces the reset state immediately.
REQ-005 start  in  1: job request, sampled only in IDLE.
REQ-006 len  in  11: activation/output vector count per job, valid range 1..2047.
REQ-007 w_base, a_base, p_base  in  11 each: xmem weight base, xmem activation base, pmem output base.
REQ-008 relu_en, acc_en  in  1 each: values driven onto inst[34] and inst[33] during OREAD.
REQ-009 ofifo_valid  in  1: core reports at least one ofifo entry readable.
REQ-010 abort  in  1: synchronous job cancel.
REQ-011 inst  out  36: registered instruction word to the core.
REQ-012 busy  out  1: high in every state except IDLE.
REQ-013 done  out  1: one-cycle pulse when a job completes.

Function
REQ-014 The inst bit map SHALL be as follows:
- [35] mode, tied to 0 (weight-stationary only)
- [34] relu, [33] accumulate
- [32] pmem CEN (active-low), [31] pmem WEN (active-low), [30:20] pmem address
- [19] xmem CEN (active-low), [18] xmem WEN (active-low), [17:7] xmem address
- [6] ofifo_rd, [5] ififo_wr (always 0), [4] ififo_rd (always 0), [3] l0_rd, [2] l0_wr, [1] execute, [0] load
REQ-015 The idle word SHALL be 36'h1800C0000: both CENs and both WENs at 1, all other bits 0; any field not listed for a state takes its idle value.
REQ-016 On start=1 with len!=0 in IDLE, all inputs SHALL be latched; inst shows the first WXFER word on the next cycle.
REQ-017 start=1 with len=0 SHALL be ignored (no busy, no done).
REQ-018 start asserted in any non-IDLE state SHALL be ignored.
REQ-019 State WXFER SHALL last col+1 cycles (k=0..col):
- k<col: xmem CEN=0, WEN=1, address w_base+k
- k>=1: l0_wr=1 (one-cycle SRAM read latency)
REQ-020 State WLOAD SHALL last col cycles with l0_rd=1 and load=1.
REQ-021 WLOAD SHALL be followed by state WSETTLE, row cycles of the idle word.
REQ-022 State AXFER SHALL last len+1 cycles, with the same pattern as WXFER using a_base and len.
REQ-023 State EXEC SHALL last len cycles with l0_rd=1 and execute=1.
REQ-024 State WAIT SHALL hold the idle word until ofifo_valid=1, then enter OREAD.
REQ-025 In state OREAD, in any cycle where fewer than len reads are issued and ofifo_valid=1, ofifo_rd SHALL be 1; otherwise ofifo_rd SHALL be 0 (stall).
REQ-026 Each ofifo_rd in cycle t SHALL produce a pmem write in cycle t+1: pmem CEN=0, WEN=0, address p_base+i, where i counts writes from 0.
REQ-027 During OREAD, relu and accumulate SHALL carry the latched relu_en and acc_en.
REQ-028 After the len-th pmem write, the FSM SHALL enter DONE for one cycle (done=1, idle word), then return to IDLE.
REQ-029 All address sums SHALL be modulo 2048 (wrap from 2047 to 0).
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE and the idle word on the next cycle, with no done pulse.
REQ-031 A pending pmem write SHALL be dropped on abort.
REQ-032 abort has priority over all other transitions and SHALL be ignored in IDLE.
REQ-033 State order SHALL be IDLE -> WXFER -> WLOAD -> WSETTLE -> AXFER -> EXEC -> WAIT -> OREAD -> DONE -> IDLE.

Reset
REQ-034 While reset=0, inst SHALL be 36'h1800C0000, busy=0, done=0, state IDLE, and all counters 0.
REQ-035 Assertion of reset mid-job SHALL discard the job; after release, the next job starts only on a new start.

Verification
REQ-036 Nominal job (row=col=8, len=4, w_base=0, a_base=16, p_base=100, ofifo_valid=1 throughout):
- xmem addresses 0..7, then 16..19
- pmem writes at 100..103
- done pulse exactly once; busy high for 9+8+8+5+4+1+5+1 cycles
REQ-037 OREAD stall (ofifo_valid toggling 1,0,0,1,...): ofifo_rd never high while ofifo_valid=0; exactly len writes, in order, at consecutive addresses.
REQ-038 Address wrap (a_base=2046, len=4): xmem addresses 2046, 2047, 0, 1.
REQ-039 Abort and busy-start:
- abort during EXEC: inst = 36'h1800C0000 the next cycle, no done
- start pulsed while busy: no effect
REQ-040 Async reset during OREAD: outputs take reset values without a clock edge; len=0 start is ignored; a new job after release completes normally.

Source files
------------

// File: rtl/core_inst_seq.sv
// Instruction sequencer for a weight-stationary PE core: one job loads a weight
// tile, streams len activations through the array and drains len outputs to pmem.
module core_inst_seq #(
    parameter int row = 8,
    parameter int col = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [10:0] len,
    input  logic [10:0] w_base,
    input  logic [10:0] a_base,
    input  logic [10:0] p_base,
    input  logic        relu_en,
    input  logic        acc_en,
    input  logic        ofifo_valid,
    input  logic        abort,
    output logic [35:0] inst,
    output logic        busy,
    output logic        done
);

    localparam int              CW        = 16;
    localparam logic [CW-1:0]   COL_CNT   = CW'(col);
    localparam logic [CW-1:0]   COL_LAST  = CW'(col - 1);
    localparam logic [CW-1:0]   ROW_LAST  = CW'(row - 1);
    localparam logic [35:0]     IDLE_WORD = 36'h1800C0000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WXFER,
        S_WLOAD,
        S_WSETTLE,
        S_AXFER,
        S_EXEC,
        S_WAIT,
        S_OREAD,
        S_DONE
    } state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [10:0]    len_reg, len_next;
    logic [10:0]    w_base_reg, w_base_next;
    logic [10:0]    a_base_reg, a_base_next;
    logic [10:0]    p_base_reg, p_base_next;
    logic           relu_reg, relu_next;
    logic           acc_reg, acc_next;
    logic           wr_shown_reg, wr_shown_next;
    logic [35:0]    inst_reg, inst_next;
    logic [CW-1:0]  len_ext_reg, len_ext_next;
    logic           ofifo_rd;

    assign len_ext_reg  = {{(CW-11){1'b0}}, len_reg};
    assign len_ext_next = {{(CW-11){1'b0}}, len_next};

    // ofifo_rd must react to ofifo_valid in the same cycle, so it bypasses the
    // instruction register; every other field is registered.
    assign ofifo_rd = (state_reg == S_OREAD) && !abort && ofifo_valid &&
                      (cnt_reg < len_ext_reg);

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        len_next      = len_reg;
        w_base_next   = w_base_reg;
        a_base_next   = a_base_reg;
        p_base_next   = p_base_reg;
        relu_next     = relu_reg;
        acc_next      = acc_reg;
        wr_shown_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start && (len != 11'd0)) begin
                    state_next  = S_WXFER;
                    cnt_next    = '0;
                    len_next    = len;
                    w_base_next = w_base;
                    a_base_next = a_base;
                    p_base_next = p_base;
                    relu_next   = relu_en;
                    acc_next    = acc_en;
                end
            end
            S_WXFER: begin
                if (cnt_reg == COL_CNT) begin
                    state_next = S_WLOAD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WLOAD: begin
                if (cnt_reg == COL_LAST) begin
                    state_next = S_WSETTLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WSETTLE: begin
                if (cnt_reg == ROW_LAST) begin
                    state_next = S_AXFER;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_AXFER: begin
                if (cnt_reg == len_ext_reg) begin
                    state_next = S_EXEC;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_EXEC: begin
                if (cnt_reg == len_ext_reg - 1'b1) begin
                    state_next = S_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WAIT: begin
                if (ofifo_valid) begin
                    state_next = S_OREAD;
                    cnt_next   = '0;
                end
            end
            S_OREAD: begin
                // cnt counts reads issued; the job ends once the last read's
                // pmem write has been shown on inst.
                wr_shown_next = ofifo_rd;
                if (ofifo_rd) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (wr_shown_reg && (cnt_reg == len_ext_reg)) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (abort && (state_reg != S_IDLE)) begin
            state_next    = S_IDLE;
            cnt_next      = '0;
            wr_shown_next = 1'b0;
        end
    end

    // The registered word is derived from the state/counter being entered, so
    // inst always describes the cycle the FSM is currently in.
    always_comb begin
        inst_next = IDLE_WORD;
        case (state_next)
            S_WXFER: begin
                if (cnt_next < COL_CNT) begin
                    inst_next[19]   = 1'b0;
                    inst_next[17:7] = w_base_next + cnt_next[10:0];
                end
                if (cnt_next != '0) begin
                    inst_next[2] = 1'b1;
                end
            end
            S_WLOAD: begin
                inst_next[3] = 1'b1;
                inst_next[0] = 1'b1;
            end
            S_AXFER: begin
                if (cnt_next < len_ext_next) begin
                    inst_next[19]   = 1'b0;
                    inst_next[17:7] = a_base_next + cnt_next[10:0];
                end
                if (cnt_next != '0) begin
                    inst_next[2] = 1'b1;
                end
            end
            S_EXEC: begin
                inst_next[3] = 1'b1;
                inst_next[1] = 1'b1;
            end
            S_OREAD: begin
                inst_next[34] = relu_next;
                inst_next[33] = acc_next;
                if (wr_shown_next) begin
                    inst_next[32]    = 1'b0;
                    inst_next[31]    = 1'b0;
                    inst_next[30:20] = p_base_reg + cnt_reg[10:0];
                end
            end
            default: begin
                inst_next = IDLE_WORD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            len_reg      <= '0;
            w_base_reg   <= '0;
            a_base_reg   <= '0;
            p_base_reg   <= '0;
            relu_reg     <= 1'b0;
            acc_reg      <= 1'b0;
            wr_shown_reg <= 1'b0;
            inst_reg     <= IDLE_WORD;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            len_reg      <= len_next;
            w_base_reg   <= w_base_next;
            a_base_reg   <= a_base_next;
            p_base_reg   <= p_base_next;
            relu_reg     <= relu_next;
            acc_reg      <= acc_next;
            wr_shown_reg <= wr_shown_next;
            inst_reg     <= inst_next;
        end
    end

    assign inst = inst_reg | {29'd0, ofifo_rd, 6'd0};
    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_DONE);

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: nominal job, ofifo stalls, address wrap,
// busy-start, abort and asynchronous reset.
module tb_core_inst_seq;

    localparam logic [35:0] IDLE_WORD = 36'h1800C0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [10:0] len;
    logic [10:0] w_base;
    logic [10:0] a_base;
    logic [10:0] p_base;
    logic        relu_en;
    logic        acc_en;
    logic        ofifo_valid;
    logic        abort;
    logic [35:0] inst;
    logic        busy;
    logic        done;

    int tests_run;
    int tests_failed;

    // per-job observations gathered by run_job
    int          xq[$];
    int          pq[$];
    int          busy_cycles, done_cnt, l0wr_cnt, exec_cnt, load_cnt;
    int          rd_cnt, bad_rd, bad_flags;
    bit          timed_out;
    logic [35:0] first_inst;

    core_inst_seq #(.row(8), .col(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .len         (len),
        .w_base      (w_base),
        .a_base      (a_base),
        .p_base      (p_base),
        .relu_en     (relu_en),
        .acc_en      (acc_en),
        .ofifo_valid (ofifo_valid),
        .abort       (abort),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one job from IDLE and records what appears on the outputs each cycle.
    task automatic run_job(input logic [10:0] l, input logic [10:0] wb,
                           input logic [10:0] ab, input logic [10:0] pb,
                           input logic re, input logic ae,
                           input int stall, input int inject_at);
        xq.delete();
        pq.delete();
        busy_cycles = 0; done_cnt = 0; l0wr_cnt = 0; exec_cnt = 0; load_cnt = 0;
        rd_cnt = 0; bad_rd = 0; bad_flags = 0; timed_out = 1'b0;
        len = l; w_base = wb; a_base = ab; p_base = pb;
        relu_en = re; acc_en = ae; start = 1'b1;
        step();
        start = 1'b0;
        len = 11'd3; w_base = 11'h555; a_base = 11'h2AA; p_base = 11'h123;
        relu_en = ~re; acc_en = ~ae;
        first_inst = inst;
        for (int c = 0; c < 600; c++) begin
            if (!busy) break;
            ofifo_valid = (stall != 0) ? ((c % 3) == 0) : 1'b1;
            start = (c == inject_at);
            #1;
            busy_cycles++;
            if (done) done_cnt++;
            if (!inst[19]) xq.push_back(int'(inst[17:7]));
            if (!inst[32]) begin
                pq.push_back(int'(inst[30:20]));
                if (inst[31] !== 1'b0 || inst[34:33] !== {re, ae}) bad_flags++;
            end
            if (inst[6]) rd_cnt++;
            if (inst[6] && !ofifo_valid) bad_rd++;
            if (inst[2]) l0wr_cnt++;
            if (inst[1]) exec_cnt++;
            if (inst[0]) load_cnt++;
            step();
        end
        start = 1'b0;
        ofifo_valid = 1'b0;
        if (busy) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; len = 11'd5; w_base = '0; a_base = '0;
        p_base = '0; relu_en = 1'b0; acc_en = 1'b0; ofifo_valid = 1'b1; abort = 1'b0;
        step(); step();
        tests_run++;
        if (inst !== IDLE_WORD) begin
            tests_failed++; $display("FAIL reset_inst: got %h expected %h", inst, IDLE_WORD);
        end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done);
        end
        reset = 1'b1; start = 1'b0; ofifo_valid = 1'b0;
        step(); step();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_release_busy: got %b expected 0", busy);
        end
        $display("[TB] test_reset complete");
    endtask

    task automatic test_nominal();
        run_job(11'd4, 11'd0, 11'd16, 11'd100, 1'b1, 1'b0, 0, -1);
        tests_run++;
        if (first_inst !== 36'h180040000) begin
            tests_failed++; $display("FAIL nominal_first_word: got %h expected 180040000", first_inst);
        end
        tests_run++;
        if (xq.size() != 12) begin
            tests_failed++; $display("FAIL nominal_xcount: got %0d expected 12", xq.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                int e;
                e = (i < 8) ? i : 16 + (i - 8);
                tests_run++;
                if (xq[i] != e) begin
                    tests_failed++; $display("FAIL nominal_xaddr[%0d]: got %0d expected %0d", i, xq[i], e);
                end
            end
        end
        tests_run++;
        if (pq.size() != 4) begin
            tests_failed++; $display("FAIL nominal_pcount: got %0d expected 4", pq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (pq[i] != 100 + i) begin
                    tests_failed++; $display("FAIL nominal_paddr[%0d]: got %0d expected %0d", i, pq[i], 100 + i);
                end
            end
        end
        tests_run++;
        if (busy_cycles != 41 || timed_out) begin
            tests_failed++; $display("FAIL nominal_busy_cycles: got %0d (timeout %0d) expected 41", busy_cycles, timed_out);
        end
        tests_run++;
        if (done_cnt != 1) begin
            tests_failed++; $display("FAIL nominal_done: got %0d pulses expected 1", done_cnt);
        end
        tests_run++;
        if (l0wr_cnt != 12 || exec_cnt != 4 || load_cnt != 8 || rd_cnt != 4) begin
            tests_failed++;
            $display("FAIL nominal_ctrl_counts: got l0wr=%0d exec=%0d load=%0d rd=%0d expected 12 4 8 4",
                     l0wr_cnt, exec_cnt, load_cnt, rd_cnt);
        end
        tests_run++;
        if (bad_flags != 0) begin
            tests_failed++; $display("FAIL nominal_write_flags: got %0d bad writes expected 0", bad_flags);
        end
        $display("[TB] test_nominal complete: %0d busy cycles", busy_cycles);
    endtask

    task automatic test_stall();
        run_job(11'd5, 11'd8, 11'd40, 11'd2000, 1'b0, 1'b1, 1, -1);
        tests_run++;
        if (bad_rd != 0) begin
            tests_failed++; $display("FAIL stall_rd_without_valid: got %0d expected 0", bad_rd);
        end
        tests_run++;
        if (rd_cnt != 5 || timed_out) begin
            tests_failed++; $display("FAIL stall_rd_count: got %0d (timeout %0d) expected 5", rd_cnt, timed_out);
        end
        tests_run++;
        if (pq.size() != 5) begin
            tests_failed++; $display("FAIL stall_pcount: got %0d expected 5", pq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests_run++;
                if (pq[i] != 2000 + i) begin
                    tests_failed++; $display("FAIL stall_paddr[%0d]: got %0d expected %0d", i, pq[i], 2000 + i);
                end
            end
        end
        tests_run++;
        if (done_cnt != 1 || bad_flags != 0) begin
            tests_failed++; $display("FAIL stall_done_flags: got done=%0d bad=%0d expected 1 0", done_cnt, bad_flags);
        end
        $display("[TB] test_stall complete: %0d busy cycles", busy_cycles);
    endtask

    task automatic test_wrap();
        int exp_x[12];
        int exp_p[4];
        exp_x = '{2044, 2045, 2046, 2047, 0, 1, 2, 3, 2046, 2047, 0, 1};
        exp_p = '{2046, 2047, 0, 1};
        run_job(11'd4, 11'd2044, 11'd2046, 11'd2046, 1'b0, 1'b0, 0, -1);
        tests_run++;
        if (xq.size() != 12 || pq.size() != 4) begin
            tests_failed++; $display("FAIL wrap_counts: got x=%0d p=%0d expected 12 4", xq.size(), pq.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                tests_run++;
                if (xq[i] != exp_x[i]) begin
                    tests_failed++; $display("FAIL wrap_xaddr[%0d]: got %0d expected %0d", i, xq[i], exp_x[i]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (pq[i] != exp_p[i]) begin
                    tests_failed++; $display("FAIL wrap_paddr[%0d]: got %0d expected %0d", i, pq[i], exp_p[i]);
                end
            end
        end
        $display("[TB] test_wrap complete");
    endtask

    task automatic test_busy_start();
        run_job(11'd3, 11'd10, 11'd500, 11'd300, 1'b0, 1'b0, 0, 20);
        tests_run++;
        if (busy_cycles != 38 || timed_out) begin
            tests_failed++; $display("FAIL busy_start_cycles: got %0d expected 38", busy_cycles);
        end
        tests_run++;
        if (xq.size() != 11 || xq[8] != 500 || xq[10] != 502) begin
            tests_failed++; $display("FAIL busy_start_aaddr: got count %0d expected 11 with 500..502", xq.size());
        end
        tests_run++;
        if (pq.size() != 3 || pq[0] != 300 || pq[2] != 302 || done_cnt != 1) begin
            tests_failed++; $display("FAIL busy_start_writes: got %0d writes, %0d done expected 3 1", pq.size(), done_cnt);
        end
        step(); step();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++; $display("FAIL busy_start_restart: got busy %b expected 0", busy);
        end
        $display("[TB] test_busy_start complete");
    endtask

    task automatic test_abort();
        bit found;
        int extra;
        len = 11'd6; w_base = 11'd0; a_base = 11'd64; p_base = 11'd10;
        ofifo_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (inst[1]) begin found = 1'b1; break; end
            step();
        end
        tests_run++;
        if (!found) begin
            tests_failed++; $display("FAIL abort_reach_exec: got no execute within 100 cycles expected one");
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        tests_run++;
        if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL abort_exec: got inst=%h busy=%b done=%b expected %h 0 0", inst, busy, done, IDLE_WORD);
        end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (busy || done) extra++;
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++; $display("FAIL abort_quiet: got %0d active cycles expected 0", extra);
        end
        // abort has no effect in IDLE, so a simultaneous start is accepted
        abort = 1'b1; start = 1'b1; len = 11'd2;
        step();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++; $display("FAIL abort_idle_start: got busy %b expected 1", busy);
        end
        step();
        abort = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || inst !== IDLE_WORD) begin
            tests_failed++; $display("FAIL abort_wxfer: got busy=%b inst=%h expected 0 %h", busy, inst, IDLE_WORD);
        end
        // abort in the cycle a read is issued: its pmem write must not appear
        len = 11'd2; start = 1'b1; ofifo_valid = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (inst[6]) begin found = 1'b1; break; end
            step();
        end
        tests_run++;
        if (!found) begin
            tests_failed++; $display("FAIL abort_reach_oread: got no ofifo_rd within 100 cycles expected one");
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        ofifo_valid = 1'b0;
        tests_run++;
        if (inst !== IDLE_WORD || busy !== 1'b0) begin
            tests_failed++; $display("FAIL abort_oread_drop: got inst=%h busy=%b expected %h 0", inst, busy, IDLE_WORD);
        end
        $display("[TB] test_abort complete");
    endtask

    task automatic test_async_reset();
        bit found;
        int extra;
        len = 11'd4; w_base = 11'd0; a_base = 11'd16; p_base = 11'd200;
        ofifo_valid = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!inst[32]) begin found = 1'b1; break; end
            step();
        end
        tests_run++;
        if (!found) begin
            tests_failed++; $display("FAIL async_reach_oread: got no pmem write within 100 cycles expected one");
        end
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (inst !== IDLE_WORD || busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL async_reset_now: got inst=%h busy=%b done=%b expected %h 0 0", inst, busy, done, IDLE_WORD);
        end
        step(); step();
        reset = 1'b1;
        extra = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (busy) extra++;
        end
        len = 11'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (busy || done) extra++;
            step();
        end
        tests_run++;
        if (extra != 0) begin
            tests_failed++; $display("FAIL async_no_restart_len0: got %0d active cycles expected 0", extra);
        end
        run_job(11'd2, 11'd0, 11'd16, 11'd50, 1'b0, 1'b0, 0, -1);
        tests_run++;
        if (done_cnt != 1 || pq.size() != 2 || timed_out) begin
            tests_failed++; $display("FAIL async_next_job: got done=%0d writes=%0d expected 1 2", done_cnt, pq.size());
        end else begin
            tests_run++;
            if (pq[0] != 50 || pq[1] != 51) begin
                tests_failed++; $display("FAIL async_next_paddr: got %0d,%0d expected 50,51", pq[0], pq[1]);
            end
        end
        $display("[TB] test_async_reset complete");
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_nominal();
        test_stall();
        test_wrap();
        test_busy_start();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
